// File: rtl/fpall_shared_logic_wrapper.sv
// FP32 add/sub/mul with one shared exponent, normalize and round datapath.
// Two-edge latency: operands captured into stage-1 registers, result registered into R.
package fpall_pkg;
  typedef enum logic [1:0] {
    FMT_FP32 = 2'd0
  } fp_fmt_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } fp_op_e;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
endpackage

module fpall_shared_logic_wrapper
  import fpall_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  fp_fmt_e     fmt_in,
  input  fp_op_e      opcode_in,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic [31:0] R
);

  // No handshake: a new operation is accepted on every rising edge and never stalls.
  fp_fmt_e     fmt_q;
  fp_op_e      op_q;
  logic [31:0] x_q, y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fmt_q <= FMT_FP32;
      op_q  <= OP_ADD;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      fmt_q <= fmt_in;
      op_q  <= opcode_in;
      x_q   <= X;
      y_q   <= Y;
    end
  end

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  logic        valid_op, is_mul;
  logic        sx, sy;
  logic [7:0]  ex, ey;
  logic [22:0] fx, fy;
  logic        zero_x, zero_y, inf_x, inf_y, nan_x, nan_y;
  logic [23:0] mx, my;

  assign valid_op = (fmt_q == FMT_FP32) &&
                    (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_MUL);
  assign is_mul   = (op_q == OP_MUL);

  // Subtraction is addition with the sign of Y flipped.
  assign sx = x_q[31];
  assign sy = y_q[31] ^ (op_q == OP_SUB);
  assign ex = x_q[30:23];
  assign ey = y_q[30:23];
  assign fx = x_q[22:0];
  assign fy = y_q[22:0];

  // Subnormals flush to zero: exponent 0 means a zero significand.
  assign zero_x = (ex == 8'h00);
  assign zero_y = (ey == 8'h00);
  assign inf_x  = (ex == 8'hFF) && (fx == '0);
  assign inf_y  = (ey == 8'hFF) && (fy == '0);
  assign nan_x  = (ex == 8'hFF) && (fx != '0);
  assign nan_y  = (ey == 8'hFF) && (fy != '0);
  assign mx     = zero_x ? 24'd0 : {1'b1, fx};
  assign my     = zero_y ? 24'd0 : {1'b1, fy};

  // Add path: swap, align with guard/round/sticky, add or subtract magnitudes.
  logic        x_big, s_big;
  logic [7:0]  e_big, e_small, e_diff;
  logic [4:0]  shamt;
  logic [23:0] m_big, m_small;
  logic [49:0] wide;
  logic [26:0] big_al, small_al;
  logic [27:0] add_sig;

  assign x_big    = {ex, fx} >= {ey, fy};
  assign e_big    = x_big ? ex : ey;
  assign e_small  = x_big ? ey : ex;
  assign m_big    = x_big ? mx : my;
  assign m_small  = x_big ? my : mx;
  assign s_big    = x_big ? sx : sy;
  assign e_diff   = e_big - e_small;
  // Beyond 26 positions every significand bit already lands in the sticky field.
  assign shamt    = (e_diff > 8'd26) ? 5'd26 : e_diff[4:0];
  assign wide     = {m_small, 26'd0} >> shamt;
  assign small_al = {wide[49:24], |wide[23:0]};
  assign big_al   = {m_big, 3'b000};
  assign add_sig  = (sx ^ sy) ? ({1'b0, big_al} - {1'b0, small_al})
                              : ({1'b0, big_al} + {1'b0, small_al});

  // Mul path: product mapped onto the same carry/lead/GRS layout as the adder.
  logic [47:0]        prod;
  logic [27:0]        mul_sig;
  logic signed [10:0] mul_exp;

  assign prod    = mx * my;
  assign mul_sig = {prod[47:21], |prod[20:0]};
  assign mul_exp = $signed({3'b000, ex}) + $signed({3'b000, ey}) - 11'sd127;

  // Shared normalize and round-to-nearest-even.
  logic [27:0]        pre_sig;
  logic signed [10:0] pre_exp, norm_exp, fin_exp;
  logic               pre_sign, rnd_up;
  logic [4:0]         lz;
  logic [26:0]        norm;
  logic [24:0]        m_rnd;
  logic [22:0]        frac;
  logic [31:0]        norm_res;

  assign pre_sig  = is_mul ? mul_sig : add_sig;
  assign pre_exp  = is_mul ? mul_exp : $signed({3'b000, e_big});
  assign pre_sign = is_mul ? (sx ^ sy) : s_big;
  assign lz       = lzc27(pre_sig[26:0]);

  always_comb begin
    norm     = '0;
    norm_exp = '0;
    if (pre_sig[27]) begin
      norm     = {pre_sig[27:2], pre_sig[1] | pre_sig[0]};
      norm_exp = pre_exp + 11'sd1;
    end else begin
      norm     = pre_sig[26:0] << lz;
      norm_exp = pre_exp - $signed({6'd0, lz});
    end
  end

  assign rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign m_rnd   = {1'b0, norm[26:3]} + {24'd0, rnd_up};
  assign frac    = m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0];
  assign fin_exp = m_rnd[24] ? (norm_exp + 11'sd1) : norm_exp;

  always_comb begin
    norm_res = '0;
    if (pre_sig == '0)
      norm_res = 32'h0000_0000;
    else if (fin_exp >= 11'sd255)
      norm_res = {pre_sign, 8'hFF, 23'd0};
    else if (fin_exp <= 11'sd0)
      norm_res = {pre_sign, 31'd0};
    else
      norm_res = {pre_sign, fin_exp[7:0], frac};
  end

  // Special operands override the arithmetic result.
  logic [31:0] res;

  always_comb begin
    res = '0;
    if (!valid_op) begin
      res = '0;
    end else if (is_mul) begin
      if (nan_x || nan_y || (inf_x && zero_y) || (zero_x && inf_y))
        res = FP_QNAN;
      else if (inf_x || inf_y)
        res = {sx ^ sy, 8'hFF, 23'd0};
      else if (zero_x || zero_y)
        res = {sx ^ sy, 31'd0};
      else
        res = norm_res;
    end else begin
      if (nan_x || nan_y)
        res = FP_QNAN;
      else if (inf_x && inf_y)
        res = (sx != sy) ? FP_QNAN : {sx, 8'hFF, 23'd0};
      else if (inf_x)
        res = {sx, 8'hFF, 23'd0};
      else if (inf_y)
        res = {sy, 8'hFF, 23'd0};
      else
        res = norm_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) R <= '0;
    else        R <= res;
  end

endmodule

// File: tb/tb_fpall_shared_logic_wrapper.sv
// Directed and random vectors for fpall_shared_logic_wrapper; expected results
// are hand-computed constants or an exact wide-integer sum rounded to nearest-even.
module tb_fpall_shared_logic_wrapper;
  import fpall_pkg::*;

  logic        clk;
  logic        rst_n;
  fp_fmt_e     fmt_in;
  fp_op_e      opcode_in;
  logic [31:0] X, Y, R;

  localparam fp_fmt_e FMT_RES = fp_fmt_e'(2'd1);
  localparam fp_op_e  OP_RES  = fp_op_e'(2'd3);

  fpall_shared_logic_wrapper dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fmt_in    (fmt_in),
    .opcode_in (opcode_in),
    .X         (X),
    .Y         (Y),
    .R         (R)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: R=%08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge; the result of an op driven two falling edges ago is on R now.
  task automatic issue(input string tag, input fp_fmt_e f, input fp_op_e o,
                       input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp);
    @(negedge clk);
    if (exp_q.size() >= 2) check(tag_q.pop_front(), R, exp_q.pop_front());
    fmt_in    = f;
    opcode_in = o;
    X         = x;
    Y         = y;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic idle();
    issue("idle_rsv", FMT_RES, OP_ADD, $urandom(), $urandom(), 32'h0000_0000);
  endtask

  // Exact sum of two operands with exponent fields 0x40..0x7A, rounded ties-to-even.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic signed [95:0] va, vb, s;
    logic [95:0]        mag, keep, rem, half;
    logic               sgn;
    int                 p, sh;
    va = $signed(96'({1'b1, a[22:0]}) << (int'(a[30:23]) - 64));
    vb = $signed(96'({1'b1, b[22:0]}) << (int'(b[30:23]) - 64));
    if (a[31]) va = -va;
    if (b[31]) vb = -vb;
    s = va + vb;
    if (s == 0) return 32'h0000_0000;
    sgn = (s < 0);
    mag = sgn ? 96'(-s) : 96'(s);
    p = 0;
    for (int i = 0; i < 96; i++) if (mag[i]) p = i;
    if (p <= 23) begin
      keep = mag << (23 - p);
    end else begin
      sh   = p - 23;
      keep = mag >> sh;
      rem  = mag & ((96'd1 << sh) - 96'd1);
      half = 96'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 96'd1;
      if (keep[24]) begin
        keep = keep >> 1;
        p    = p + 1;
      end
    end
    return {sgn, 8'(p + 41), keep[22:0]};
  endfunction

  task automatic mid_stream_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_async", R, 32'h0000_0000);
    exp_q.delete();
    tag_q.delete();
    @(posedge clk);
    #1 check("rst_hold", R, 32'h0000_0000);
    @(negedge clk);
    fmt_in = FMT_RES;
    rst_n  = 1'b1;
    @(negedge clk);
    check("rst_flush", R, 32'h0000_0000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b, e;
    rst_n     = 1'b0;
    fmt_in    = FMT_FP32;
    opcode_in = OP_ADD;
    X         = 32'h3F80_0000;
    Y         = 32'h4000_0000;
    #3 check("reset_async", R, 32'h0000_0000);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", R, 32'h0000_0000);
    @(negedge clk);
    fmt_in = FMT_RES;
    rst_n  = 1'b1;

    // Directed vectors, issued back to back
    issue("add_1p2",        FMT_FP32, OP_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    issue("add_cancel",     FMT_FP32, OP_ADD, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
    issue("tie_even_dn",    FMT_FP32, OP_ADD, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    issue("tie_even_up",    FMT_FP32, OP_ADD, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
    issue("above_tie",      FMT_FP32, OP_ADD, 32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001);
    issue("rnd_carry",      FMT_FP32, OP_ADD, 32'h3F7F_FFFF, 32'h3300_0000, 32'h3F80_0000);
    issue("add_ovf",        FMT_FP32, OP_ADD, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    issue("inf_m_inf",      FMT_FP32, OP_ADD, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    issue("mul_2x3",        FMT_FP32, OP_MUL, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    issue("sub_3m1",        FMT_FP32, OP_SUB, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000);
    issue("sub_far_sticky", FMT_FP32, OP_SUB, 32'h3F80_0000, 32'h2F80_0000, 32'h3F80_0000);
    issue("sub_lzc",        FMT_FP32, OP_SUB, 32'h3F80_0000, 32'h3F7F_FFFF, 32'h3380_0000);
    issue("sub_self",       FMT_FP32, OP_SUB, 32'h4049_0FDB, 32'h4049_0FDB, 32'h0000_0000);
    issue("neg_zero_sum",   FMT_FP32, OP_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
    issue("ftz_add",        FMT_FP32, OP_ADD, 32'h0040_0000, 32'h3F80_0000, 32'h3F80_0000);
    issue("nan_in",         FMT_FP32, OP_ADD, 32'h7FA0_0000, 32'h3F80_0000, 32'h7FC0_0000);
    issue("inf_prop",       FMT_FP32, OP_ADD, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);
    issue("sub_neg_inf",    FMT_FP32, OP_SUB, 32'h3F80_0000, 32'hFF80_0000, 32'h7F80_0000);
    issue("sub_inf_inf",    FMT_FP32, OP_SUB, 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000);
    issue("mul_neg",        FMT_FP32, OP_MUL, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000);
    issue("mul_round",      FMT_FP32, OP_MUL, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
    issue("mul_carry_norm", FMT_FP32, OP_MUL, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
    issue("mul_ovf",        FMT_FP32, OP_MUL, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000);
    issue("mul_unf",        FMT_FP32, OP_MUL, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
    issue("mul_unf_neg",    FMT_FP32, OP_MUL, 32'h8080_0000, 32'h0080_0000, 32'h8000_0000);
    issue("zero_x_inf",     FMT_FP32, OP_MUL, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000);
    issue("mul_inf",        FMT_FP32, OP_MUL, 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
    issue("mul_neg_zero",   FMT_FP32, OP_MUL, 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000);
    issue("rsv_fmt",        FMT_RES,  OP_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0000);
    issue("rsv_op",         FMT_FP32, OP_RES, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0000);
    issue("b2b_add",        FMT_FP32, OP_ADD, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
    issue("b2b_mul",        FMT_FP32, OP_MUL, 32'h4040_0000, 32'h4040_0000, 32'h4110_0000);
    issue("b2b_sub",        FMT_FP32, OP_SUB, 32'h4080_0000, 32'h4040_0000, 32'h3F80_0000);
    idle();
    idle();
    // These two are in flight when reset hits and must be discarded.
    issue("lost_a",         FMT_FP32, OP_ADD, 32'h40A0_0000, 32'h40A0_0000, 32'h4120_0000);
    issue("lost_b",         FMT_FP32, OP_MUL, 32'h40A0_0000, 32'h40A0_0000, 32'h41C8_0000);
    mid_stream_reset();

    issue("post_rst_add",   FMT_FP32, OP_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    issue("post_rst_mul",   FMT_FP32, OP_MUL, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);

    // Random adds with normal results
    for (int i = 0; i < 4000; i++) begin
      a = {1'($urandom_range(1, 0)), 8'($urandom_range(32'h7A, 32'h40)), 23'($urandom())};
      b = {1'($urandom_range(1, 0)), 8'($urandom_range(32'h7A, 32'h40)), 23'($urandom())};
      e = ref_add(a, b);
      if (e[30:23] != 8'h00 && e[30:23] != 8'hFF)
        issue("rand_add", FMT_FP32, OP_ADD, a, b, e);
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpall_shared_logic_wrapper.md
FPALL_SHARED_LOGIC_WRAPPER -- requirements
Module: fpall_shared_logic_wrapper

Interface
REQ-001 Parameters: none; formats and opcodes come from package fpall_pkg (fp_fmt_e, fp_op_e).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 fmt_in  input  fp_fmt_e  operand format; FP32 = IEEE-754 binary32, all other encodings reserved.
REQ-005 opcode_in  input  fp_op_e  operation; OP_ADD (X+Y), OP_SUB (X-Y), OP_MUL (X*Y); other encodings reserved.
REQ-006 X  input  32  operand A, binary32 bit pattern.
REQ-007 Y  input  32  operand B, binary32 bit pattern.
REQ-008 R  output  32  registered result, binary32 bit pattern.

Function
REQ-009 Pipeline: inputs (fmt_in, opcode_in, X, Y) SHALL be captured at rising edge k; R SHALL show that operation's result after rising edge k+1 (2-edge latency, counting the capture edge).
REQ-010 Throughput SHALL be one operation per cycle; no handshake, no stall, and a new operation may start every edge.
REQ-011 Add/sub and multiply SHALL share the exponent, normalize and round datapath; sharing SHALL NOT change the numeric results.
REQ-012 OP_SUB SHALL equal OP_ADD with Y's sign bit inverted.
REQ-013 Add: align the smaller-exponent significand with at least guard, round and sticky bits; the sticky bit SHALL OR all shifted-out bits, including shifts larger than 26.
REQ-014 Add: effective subtraction SHALL normalize by leading-zero count; carry-out SHALL right-shift by 1 and increment the exponent.
REQ-015 Mul: take the 24x24-bit significand product; exponent = eX + eY - 127; normalize by 0 or 1 bit; sign = sX XOR sY.
REQ-016 Rounding SHALL be round-to-nearest, ties-to-even; results SHALL be bit-exact with IEEE-754 for normal inputs that give normal results.
REQ-017 A rounding carry SHALL renormalize the significand and increment the exponent.
REQ-018 An exact-zero add/sub result SHALL be +0 (0x00000000).
REQ-019 Subnormal inputs SHALL be treated as signed zero (flush-to-zero).
REQ-020 A result whose exponent underflows below the normal range SHALL be signed zero.
REQ-021 A result whose exponent overflows SHALL be signed infinity (0x7F800000 / 0xFF800000).
REQ-022 Any NaN input SHALL give canonical NaN 0x7FC00000; so SHALL inf-inf of opposite effective signs and 0*inf.
REQ-023 Infinity operands otherwise SHALL propagate with IEEE sign rules.
REQ-024 A reserved fmt_in or opcode_in SHALL give R = 0x00000000 at the normal latency.
REQ-025 R SHALL be combinationally independent of the current inputs; it depends only on pipeline registers.

Reset
REQ-026 While rst_n = 0, all pipeline registers and R SHALL be 0x00000000, with no clock required.
REQ-027 On rst_n deassertion, the first valid R SHALL appear 2 edges after the first captured input.
REQ-028 An operation in flight when reset asserts SHALL be discarded.

Verification
REQ-029 ADD 0x3F800000 + 0x40000000 -> R = 0x40400000 two edges later; ADD 0x3F800000 + 0xBF800000 -> 0x00000000.
REQ-030 Ties-to-even: ADD 0x3F800000 + 0x33800000 -> 0x3F800000; ADD 0x3F800001 + 0x33800000 -> 0x3F800002.
REQ-031 Overflow and NaN: ADD 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000; ADD 0x7F800000 + 0xFF800000 -> 0x7FC00000.
REQ-032 MUL 0x40000000 * 0x40400000 -> 0x40C00000; SUB 0x40400000 - 0x3F800000 -> 0x40000000.
REQ-033 Back-to-back different ops on consecutive edges -> each result appears in order, one per cycle; assert rst_n = 0 mid-stream -> R = 0 at once.
REQ-034 Random check: 4000 FP32 ADD vectors, exponent field 0x40-0x7A, random sign and fraction, filtered to normal results -> R bit-exact to the shortreal sum, 0 mismatches.
